mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32I core. Sits between ex_mem and mem_wb.
- Issues load/store transactions on the data bus using a req/ack handshake.
- Aligns and sign/zero-extends load data, and generates byte enables for stores.
- Holds the pipeline through stall_req_o until the transaction completes, then presents a stable result for mem_wb to capture.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_stage_load_ext.sv | 26 ++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types, funct3 codes and store-side helpers for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
    logic            we;
  } dbus_req_t;

  function automatic logic mem_misaligned(input logic [F3_W-1:0] f3, input logic [1:0] off);
    logic half;
    logic word;
    half = (f3 == F3_LH) || (f3 == F3_LHU);
    word = (f3 == F3_LW);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [F3_W-1:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return BE_W'(4'b0001 << off);
      F3_SH:   return BE_W'(4'b0011 << off);
      F3_SW:   return 4'b1111;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [F3_W-1:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      F3_SB:   return {4{d[7:0]}};
      F3_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load lane select and sign/zero extension of the returned bus word.
import mem_stage_pkg::*;

module mem_load_ext (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = '0;
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = shifted;
      F3_LBU:  data = {24'd0, shifted[7:0]};
      F3_LHU:  data = {16'd0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-bus load/store over req/ack, stalls the pipe until
// completion or timeout, then presents the result for one cycle in DONE.
import mem_stage_pkg::*;

module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  rd_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [31:0] reg_data_o,
  output logic [31:0] mem_data_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic [4:0]  rd_o,
  output logic        stall_req_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  mem_state_e       state;
  dbus_req_t        req_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       off_q;
  logic [F3_W-1:0]  f3_q;
  logic             fault_q;
  logic             mem_op;
  logic             mis;
  logic             accept;
  logic             last_wait;
  logic [XLEN-1:0]  load_data;

  assign mem_op    = MemRead_i | MemWrite_i;
  assign mis       = mem_misaligned(funct3_i, alu_result_i[1:0]);
  assign accept    = (state == MEM_IDLE) && mem_op && !mis;
  assign last_wait = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign misalign_o  = (state == MEM_IDLE) && mem_op && mis;
  assign stall_req_o = accept || (state == MEM_WAIT);
  assign RegWrite_o  = RegWrite_i && !misalign_o && !((state == MEM_DONE) && fault_q);
  assign reg_data_o  = alu_result_i;
  assign MemtoReg_o  = MemtoReg_i;
  assign rd_o        = rd_i;

  assign dbus_we_o    = req_q.we;
  assign dbus_addr_o  = req_q.addr;
  assign dbus_wdata_o = req_q.wdata;
  assign dbus_be_o    = req_q.be;

  mem_load_ext u_load_ext (
    .rdata  (dbus_rdata_i),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // Bus transaction FSM; ack has priority over timeout expiry.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= MEM_IDLE;
      req_q      <= '0;
      wait_cnt   <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      fault_q    <= 1'b0;
      dbus_req_o <= 1'b0;
      bus_err_o  <= 1'b0;
      mem_data_o <= '0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (accept) begin
            state       <= MEM_WAIT;
            dbus_req_o  <= 1'b1;
            req_q.addr  <= {alu_result_i[31:2], 2'b00};
            req_q.wdata <= store_wdata(funct3_i, store_data_i);
            req_q.be    <= store_be(funct3_i, alu_result_i[1:0]);
            req_q.we    <= MemWrite_i;
            off_q       <= alu_result_i[1:0];
            f3_q        <= funct3_i;
            wait_cnt    <= '0;
            fault_q     <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (dbus_ack_i) begin
            dbus_req_o <= 1'b0;
            state      <= MEM_DONE;
            if (!req_q.we) mem_data_o <= load_data;
          end else if (last_wait) begin
            dbus_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
            fault_q    <= 1'b1;
            state      <= MEM_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        MEM_DONE: begin
          state   <= MEM_IDLE;
          fault_q <= 1'b0;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] alu_result_i, store_data_i, dbus_rdata_i;
  logic        MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, dbus_ack_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        dbus_req_o, dbus_we_o, MemtoReg_o, RegWrite_o, stall_req_o, misalign_o, bus_err_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, reg_data_o, mem_data_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  rd_o;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .rd_i(rd_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .reg_data_o(reg_data_o), .mem_data_o(mem_data_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .rd_o(rd_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  logic        exp_req, exp_we, exp_stall, exp_mis, exp_err, exp_rw, exp_m2r;
  logic [31:0] exp_addr, exp_wdata, exp_mem, exp_reg;
  logic [3:0]  exp_be;
  logic [4:0]  exp_rd;
  logic [31:0] m_mem_data;

  int          cap_stall, cap_req;
  logic        cap_err, cap_mis, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata, cap_done_mem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: spec rules as plain arithmetic.
  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'b010 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (f3 == 3'b000) return 4'(1 << off);
    if (f3 == 3'b001) return 4'(3 << off);
    if (f3 == 3'b010) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v, b, h;
    v = w >> (8 * int'(a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("stall", 32'(stall_req_o), 32'(exp_stall));
      chk("req", 32'(dbus_req_o), 32'(exp_req));
      chk("misalign", 32'(misalign_o), 32'(exp_mis));
      chk("bus_err", 32'(bus_err_o), 32'(exp_err));
      chk("regwrite", 32'(RegWrite_o), 32'(exp_rw));
      chk("mem_data", mem_data_o, exp_mem);
      chk("reg_data", reg_data_o, exp_reg);
      chk("memtoreg", 32'(MemtoReg_o), 32'(exp_m2r));
      chk("rd", 32'(rd_o), 32'(exp_rd));
      if (exp_req) begin
        chk("addr", dbus_addr_o, exp_addr);
        chk("we", 32'(dbus_we_o), 32'(exp_we));
        if (exp_we) begin
          chk("be", 32'(dbus_be_o), 32'(exp_be));
          chk("wdata", dbus_wdata_o, exp_wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
    cap_stall += int'(stall_req_o);
    cap_req   += int'(dbus_req_o);
  endtask

  task automatic drive_in(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic rw);
    MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; alu_result_i = a;
    store_data_i = sd; RegWrite_i = rw; MemtoReg_i = rd; rd_i = a[6:2] ^ 5'd3;
    exp_reg = a; exp_m2r = rd; exp_rd = a[6:2] ^ 5'd3;
  endtask

  task automatic nop();
    step();
    drive_in(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1);
    dbus_ack_i = 1'b0;
    exp_req = 0; exp_stall = 0; exp_mis = 0; exp_err = 0; exp_rw = 1; exp_mem = m_mem_data;
    sample();
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int ack_at, input logic [31:0] rdata, input logic rw);
    logic mem, mis, acked;
    int k;
    mem = rd | wr;
    mis = mem && m_mis(f3, a);
    cap_stall = 0; cap_req = 0; cap_err = 0;
    step();
    drive_in(rd, wr, f3, a, sd, rw);
    dbus_ack_i = 1'b0;
    exp_req = 0; exp_stall = mem && !mis; exp_mis = mis; exp_err = 0;
    exp_rw = rw && !mis; exp_mem = m_mem_data;
    sample();
    cap_mis = misalign_o;
    if (!mem || mis) return;
    acked = 0;
    k = 0;
    while (!acked && k < int'(TO)) begin
      k++;
      step();
      acked = (k == ack_at);
      dbus_ack_i = acked;
      dbus_rdata_i = acked ? rdata : 32'h5A5A_0F0F;
      exp_req = 1; exp_we = wr; exp_addr = a & 32'hFFFF_FFFC;
      exp_be = m_be(f3, a); exp_wdata = m_wdata(f3, sd);
      exp_stall = 1; exp_mis = 0; exp_rw = rw;
      sample();
      if (k == 1) begin cap_be = dbus_be_o; cap_wdata = dbus_wdata_o; cap_we = dbus_we_o; end
    end
    step();
    dbus_ack_i = 1'b0;
    dbus_rdata_i = 32'h5A5A_0F0F;
    if (acked && !wr) m_mem_data = m_load(f3, a, rdata);
    exp_req = 0; exp_stall = 0; exp_err = !acked; exp_rw = rw && acked; exp_mem = m_mem_data;
    sample();
    cap_done_mem = mem_data_o;
    cap_err = bus_err_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    drive_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
    m_mem_data = 32'h0;
    exp_req = 0; exp_we = 0; exp_stall = 0; exp_mis = 0; exp_err = 0; exp_rw = 0;
    exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_mem = 0;
    step();
    chk_en = 1'b1;
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("reset_req", 32'(dbus_req_o), 32'h0);
    chk("reset_mem_data", mem_data_o, 32'h0);

    run_op(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 1);
    chk("lw_data", cap_done_mem, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", 32'(cap_stall), 32'd3);
    nop();
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h8012_3456, 1);
    chk("lb_sign", cap_done_mem, 32'hFFFF_FF80);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h8012_3456, 1);
    chk("lbu_zero", cap_done_mem, 32'h0000_0080);
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h8001_1234, 1);
    chk("lh_sign", cap_done_mem, 32'hFFFF_8001);
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h8001_1234, 0);
    chk("lhu_zero", cap_done_mem, 32'h0000_8001);
    run_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'h0, 0);
    chk("sh_be", 32'(cap_be), 32'h0000_000C);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(cap_we), 32'h1);
    chk("sh_mem_kept", cap_done_mem, 32'h0000_8001);
    run_op(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 1, 32'h0, 0);
    chk("sb_be", 32'(cap_be), 32'h0000_0002);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    run_op(1, 1, 3'b010, 32'h204, 32'hCAFE_BABE, 1, 32'h1111_1111, 0);
    chk("rw_as_store_we", 32'(cap_we), 32'h1);
    chk("rw_as_store_be", 32'(cap_be), 32'h0000_000F);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1);
    chk("mis_pulse", 32'(cap_mis), 32'h1);
    chk("mis_no_req", 32'(cap_req), 32'h0);
    run_op(1, 0, 3'b001, 32'h103, 32'h0, 1, 32'h0, 1);
    nop();
    run_op(1, 0, 3'b010, 32'h108, 32'h0, 0, 32'h0, 1);
    chk("to_bus_err", 32'(cap_err), 32'h1);
    chk("to_req_cycles", 32'(cap_req), 32'd4);
    nop();
    run_op(1, 0, 3'b010, 32'h10C, 32'h0, 4, 32'h0BAD_CAFE, 1);
    chk("ack_at_limit_no_err", 32'(cap_err), 32'h0);
    chk("ack_at_limit_data", cap_done_mem, 32'h0BAD_CAFE);
    run_op(1, 0, 3'b011, 32'h104, 32'h0, 1, 32'hFFFF_FFFF, 1);
    chk("undef_f3_zero", cap_done_mem, 32'h0);

    // Reset asserted mid-WAIT, then a stale ack must be ignored.
    step();
    drive_in(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
    exp_req = 0; exp_stall = 1; exp_mis = 0; exp_err = 0; exp_rw = 1; exp_mem = m_mem_data;
    sample();
    step();
    exp_req = 1; exp_we = 0; exp_addr = 32'h300; exp_stall = 1;
    sample();
    step();
    rst_i = 1'b0;
    drive_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    exp_rw = 0;
    sample();
    step();
    rst_i = 1'b1;
    m_mem_data = 32'h0;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    exp_req = 0; exp_stall = 0; exp_mem = m_mem_data;
    sample();
    chk("rst_req_dropped", 32'(dbus_req_o), 32'h0);
    step();
    dbus_ack_i = 1'b0;
    sample();
    chk("late_ack_ignored", mem_data_o, 32'h0);
    nop();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
